// File: rtl/queue_op_issuer_if.sv
// Bundle of the host command/response channel and the six queue op request/completion channels.
interface queue_op_issuer_if #(
    parameter int unsigned p_ptrwidth  = 3,
    parameter int unsigned p_chanwidth = 8
);
    logic                   cmd_val;
    logic                   cmd_rdy;
    logic [2:0]             cmd_op;
    logic [p_ptrwidth-1:0]  cmd_tag;
    logic [p_chanwidth-1:0] cmd_data;

    logic                   resp_val;
    logic                   resp_rdy;
    logic [2:0]             resp_op;
    logic [p_chanwidth-1:0] resp_data;
    logic                   resp_err;

    logic enq_back_en, enq_front_en, deq_front_en, deq_back_en, upd_en, del_en;
    logic enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl, upd_cpl, del_cpl;

    logic [p_chanwidth-1:0] enq_back_data;
    logic [p_chanwidth-1:0] enq_front_data;
    logic [p_chanwidth-1:0] upd_data_in;
    logic [p_ptrwidth-1:0]  upd_tag_in;
    logic [p_ptrwidth-1:0]  del_tag_in;
    logic [p_ptrwidth-1:0]  enq_back_tag_out;
    logic [p_ptrwidth-1:0]  enq_front_tag_out;
    logic [p_chanwidth-1:0] deq_front_data;
    logic [p_chanwidth-1:0] deq_back_data;

    // Environment side: issues commands, accepts responses, plays the queue.
    modport master (
        output cmd_val, cmd_op, cmd_tag, cmd_data, resp_rdy,
        output enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl, upd_cpl, del_cpl,
        output enq_back_tag_out, enq_front_tag_out, deq_front_data, deq_back_data,
        input  cmd_rdy, resp_val, resp_op, resp_data, resp_err,
        input  enq_back_en, enq_front_en, deq_front_en, deq_back_en, upd_en, del_en,
        input  enq_back_data, enq_front_data, upd_data_in, upd_tag_in, del_tag_in
    );

    // Issuer side.
    modport slave (
        input  cmd_val, cmd_op, cmd_tag, cmd_data, resp_rdy,
        input  enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl, upd_cpl, del_cpl,
        input  enq_back_tag_out, enq_front_tag_out, deq_front_data, deq_back_data,
        output cmd_rdy, resp_val, resp_op, resp_data, resp_err,
        output enq_back_en, enq_front_en, deq_front_en, deq_back_en, upd_en, del_en,
        output enq_back_data, enq_front_data, upd_data_in, upd_tag_in, del_tag_in
    );
endinterface

// File: rtl/queue_op_issuer.sv
// Single-outstanding command issuer: turns one host command into one queue op request,
// waits for its completion (bounded by p_timeout) and returns a response.
`ifndef TOP_DEPTH
`define TOP_DEPTH 8
`endif
`ifndef TOP_CHANWIDTH
`define TOP_CHANWIDTH 8
`endif

module queue_op_issuer #(
    parameter int unsigned p_depth     = `TOP_DEPTH,
    parameter int unsigned p_ptrwidth  = $clog2(p_depth),
    parameter int unsigned p_chanwidth = `TOP_CHANWIDTH,
    parameter int unsigned p_timeout   = 16
) (
    input logic              clk,
    input logic              rst,
    queue_op_issuer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(p_timeout + 1);
    localparam int unsigned N_OPS = 6;

    localparam logic [2:0] OP_ENQ_BACK  = 3'd0;
    localparam logic [2:0] OP_ENQ_FRONT = 3'd1;
    localparam logic [2:0] OP_DEQ_FRONT = 3'd2;
    localparam logic [2:0] OP_DEQ_BACK  = 3'd3;
    localparam logic [2:0] OP_UPD       = 3'd4;
    localparam logic [2:0] OP_DEL       = 3'd5;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                 state_q, state_d;
    logic [N_OPS-1:0]       en_q, en_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             op_q, op_d;
    logic [p_chanwidth-1:0] eb_data_q, eb_data_d;
    logic [p_chanwidth-1:0] ef_data_q, ef_data_d;
    logic [p_chanwidth-1:0] upd_data_q, upd_data_d;
    logic [p_ptrwidth-1:0]  upd_tag_q, upd_tag_d;
    logic [p_ptrwidth-1:0]  del_tag_q, del_tag_d;
    logic                   cmd_rdy_q, cmd_rdy_d;
    logic                   resp_val_q, resp_val_d;
    logic                   resp_err_q, resp_err_d;
    logic [2:0]             resp_op_q, resp_op_d;
    logic [p_chanwidth-1:0] resp_data_q, resp_data_d;

    logic [N_OPS-1:0]       cpl_vec;
    logic [p_chanwidth-1:0] ret_val;
    logic                   drop;

    assign cpl_vec = {bus.del_cpl, bus.upd_cpl, bus.deq_back_cpl,
                      bus.deq_front_cpl, bus.enq_front_cpl, bus.enq_back_cpl};

    // Value the queue hands back for the op in flight.
    always_comb begin
        ret_val = '0;
        unique case (op_q)
            OP_ENQ_BACK:  ret_val = p_chanwidth'(bus.enq_back_tag_out);
            OP_ENQ_FRONT: ret_val = p_chanwidth'(bus.enq_front_tag_out);
            OP_DEQ_FRONT: ret_val = bus.deq_front_data;
            OP_DEQ_BACK:  ret_val = bus.deq_back_data;
            default:      ret_val = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        eb_data_d   = eb_data_q;
        ef_data_d   = ef_data_q;
        upd_data_d  = upd_data_q;
        upd_tag_d   = upd_tag_q;
        del_tag_d   = del_tag_q;
        resp_op_d   = resp_op_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        drop        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_val && cmd_rdy_q) begin
                    op_d = bus.cmd_op;
                    if (bus.cmd_op > OP_DEL) begin
                        state_d     = RESP;
                        resp_op_d   = bus.cmd_op;
                        resp_data_d = '0;
                        resp_err_d  = 1'b1;
                    end else begin
                        state_d    = ISSUE;
                        cnt_d      = '0;
                        en_d       = N_OPS'(1) << bus.cmd_op;
                        eb_data_d  = (bus.cmd_op == OP_ENQ_BACK)  ? bus.cmd_data : '0;
                        ef_data_d  = (bus.cmd_op == OP_ENQ_FRONT) ? bus.cmd_data : '0;
                        upd_data_d = (bus.cmd_op == OP_UPD)       ? bus.cmd_data : '0;
                        upd_tag_d  = (bus.cmd_op == OP_UPD)       ? bus.cmd_tag  : '0;
                        del_tag_d  = (bus.cmd_op == OP_DEL)       ? bus.cmd_tag  : '0;
                    end
                end
            end
            ISSUE: begin
                // Completion is checked before the limit so a cpl on the last cycle still wins.
                if (|(cpl_vec & en_q)) begin
                    state_d     = RESP;
                    resp_op_d   = op_q;
                    resp_data_d = ret_val;
                    resp_err_d  = 1'b0;
                    drop        = 1'b1;
                end else if (cnt_q == CNT_W'(p_timeout - 1)) begin
                    state_d     = RESP;
                    resp_op_d   = op_q;
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                    drop        = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.resp_rdy) begin
                    state_d     = IDLE;
                    resp_op_d   = '0;
                    resp_data_d = '0;
                    resp_err_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (drop) begin
            en_d       = '0;
            eb_data_d  = '0;
            ef_data_d  = '0;
            upd_data_d = '0;
            upd_tag_d  = '0;
            del_tag_d  = '0;
        end

        cmd_rdy_d  = (state_d == IDLE);
        resp_val_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            en_q        <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            eb_data_q   <= '0;
            ef_data_q   <= '0;
            upd_data_q  <= '0;
            upd_tag_q   <= '0;
            del_tag_q   <= '0;
            cmd_rdy_q   <= 1'b1;
            resp_val_q  <= 1'b0;
            resp_err_q  <= 1'b0;
            resp_op_q   <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            eb_data_q   <= eb_data_d;
            ef_data_q   <= ef_data_d;
            upd_data_q  <= upd_data_d;
            upd_tag_q   <= upd_tag_d;
            del_tag_q   <= del_tag_d;
            cmd_rdy_q   <= cmd_rdy_d;
            resp_val_q  <= resp_val_d;
            resp_err_q  <= resp_err_d;
            resp_op_q   <= resp_op_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign bus.cmd_rdy        = cmd_rdy_q;
    assign bus.resp_val       = resp_val_q;
    assign bus.resp_op        = resp_op_q;
    assign bus.resp_data      = resp_data_q;
    assign bus.resp_err       = resp_err_q;
    assign bus.enq_back_en    = en_q[OP_ENQ_BACK];
    assign bus.enq_front_en   = en_q[OP_ENQ_FRONT];
    assign bus.deq_front_en   = en_q[OP_DEQ_FRONT];
    assign bus.deq_back_en    = en_q[OP_DEQ_BACK];
    assign bus.upd_en         = en_q[OP_UPD];
    assign bus.del_en         = en_q[OP_DEL];
    assign bus.enq_back_data  = eb_data_q;
    assign bus.enq_front_data = ef_data_q;
    assign bus.upd_data_in    = upd_data_q;
    assign bus.upd_tag_in     = upd_tag_q;
    assign bus.del_tag_in     = del_tag_q;
endmodule

// File: tb/tb_queue_op_issuer.sv
// Bench for queue_op_issuer: directed scenarios plus randomized transactions against a
// transaction-level model of the expected response, enable duration and latency.
module tb_queue_op_issuer;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    queue_op_issuer_if #(.p_ptrwidth(3), .p_chanwidth(8)) bus ();

    queue_op_issuer #(
        .p_depth(8), .p_ptrwidth(3), .p_chanwidth(8), .p_timeout(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [7:0] en_cycles;
        logic [7:0] lat;
        logic [2:0] op;
        logic [7:0] data;
        logic       err;
    } res_t;

    res_t       obs_res;
    logic [7:0] obs_proto;
    int         bad_en, bad_pay, bad_ctl, unstable;
    bit         no_resp, rdy_at_accept, after_val, after_rdy;

    // Expected outcome of one command from the opcode, completion cycle and queue return value.
    function automatic res_t model(input logic [2:0] op, input int cpl_at, input logic [7:0] ret);
        res_t r;
        r.op = op;
        if (op > 3'd5) begin
            r.en_cycles = 8'd0; r.lat = 8'd1; r.data = 8'h00; r.err = 1'b1;
        end else if (cpl_at >= 1 && cpl_at <= TIMEOUT) begin
            r.en_cycles = 8'(cpl_at);
            r.lat       = 8'(cpl_at + 1);
            r.err       = 1'b0;
            r.data      = (op <= 3'd1) ? {5'b0, ret[2:0]} : (op <= 3'd3) ? ret : 8'h00;
        end else begin
            r.en_cycles = 8'(TIMEOUT); r.lat = 8'(TIMEOUT + 1); r.data = 8'h00; r.err = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [5:0] en_vec();
        return {bus.del_en, bus.upd_en, bus.deq_back_en, bus.deq_front_en, bus.enq_front_en, bus.enq_back_en};
    endfunction

    function automatic logic [29:0] pay_vec();
        return {bus.enq_back_data, bus.enq_front_data, bus.upd_data_in, bus.upd_tag_in, bus.del_tag_in};
    endfunction

    task automatic drive_cpl(input logic [5:0] c);
        bus.enq_back_cpl  = c[0];
        bus.enq_front_cpl = c[1];
        bus.deq_front_cpl = c[2];
        bus.deq_back_cpl  = c[3];
        bus.upd_cpl       = c[4];
        bus.del_cpl       = c[5];
    endtask

    task automatic drive_idle();
        bus.cmd_val = 1'b0; bus.cmd_op = 3'd0; bus.cmd_tag = 3'd0; bus.cmd_data = 8'd0;
        bus.resp_rdy = 1'b0;
        bus.enq_back_tag_out = 3'd0; bus.enq_front_tag_out = 3'd0;
        bus.deq_front_data = 8'd0; bus.deq_back_data = 8'd0;
        drive_cpl(6'd0);
    endtask

    // Plays host and queue for one command; called and returns at a falling edge.
    task automatic run_txn(input logic [2:0] op, input logic [2:0] tag, input logic [7:0] data,
                           input int cpl_at, input logic [7:0] ret, input int hold,
                           input logic [5:0] stray);
        res_t        e;
        logic [5:0]  en_now, en_exp, c;
        logic [29:0] pay_exp;
        bit          seen;
        int          cyc;
        e = model(op, cpl_at, ret);
        bad_en = 0; bad_pay = 0; bad_ctl = 0; unstable = 0;
        no_resp = 0; after_val = 0; after_rdy = 1;
        obs_res = '0;
        rdy_at_accept = bus.cmd_rdy;
        bus.cmd_val = 1'b1; bus.cmd_op = op; bus.cmd_tag = tag; bus.cmd_data = data;
        bus.enq_back_tag_out  = (op == 3'd0) ? ret[2:0] : 3'($urandom);
        bus.enq_front_tag_out = (op == 3'd1) ? ret[2:0] : 3'($urandom);
        bus.deq_front_data    = (op == 3'd2) ? ret : 8'($urandom);
        bus.deq_back_data     = (op == 3'd3) ? ret : 8'($urandom);
        @(posedge clk); @(negedge clk);
        bus.cmd_val = 1'b0; bus.cmd_op = 3'($urandom); bus.cmd_tag = 3'($urandom); bus.cmd_data = 8'($urandom);
        seen = 0;
        cyc  = 1;
        while (!seen && cyc <= 3 * TIMEOUT) begin
            en_now  = en_vec();
            en_exp  = (op <= 3'd5 && cyc <= int'(e.en_cycles)) ? 6'(6'd1 << op) : 6'd0;
            pay_exp = '0;
            if (en_exp != 6'd0) begin
                case (op)
                    3'd0: pay_exp[29:22] = data;
                    3'd1: pay_exp[21:14] = data;
                    3'd4: begin pay_exp[13:6] = data; pay_exp[5:3] = tag; end
                    3'd5: pay_exp[2:0] = tag;
                    default: ;
                endcase
            end
            if (en_now !== en_exp) bad_en++;
            if (pay_vec() !== pay_exp) bad_pay++;
            if (en_now != 6'd0) obs_res.en_cycles = obs_res.en_cycles + 8'd1;
            if (bus.cmd_rdy !== 1'b0) bad_ctl++;
            if (bus.resp_val === 1'b1) begin
                seen         = 1;
                obs_res.lat  = 8'(cyc);
                obs_res.op   = bus.resp_op;
                obs_res.data = bus.resp_data;
                obs_res.err  = bus.resp_err;
                drive_cpl(6'd0);
            end else begin
                c = stray;
                if (op <= 3'd5) c[op] = (cyc == cpl_at);
                drive_cpl(c);
                @(posedge clk); @(negedge clk);
                cyc++;
            end
        end
        if (!seen) begin
            // No response: pull reset so later scenarios start from a known state.
            no_resp = 1;
            drive_cpl(6'd0);
            rst = 1'b0;
            @(negedge clk); rst = 1'b1;
            @(negedge clk);
        end else begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); @(negedge clk);
                if (bus.resp_val !== 1'b1 || bus.resp_op !== obs_res.op || bus.resp_data !== obs_res.data ||
                    bus.resp_err !== obs_res.err || bus.cmd_rdy !== 1'b0 || en_vec() !== 6'd0)
                    unstable++;
            end
            bus.resp_rdy = 1'b1;
            @(posedge clk); @(negedge clk);
            bus.resp_rdy = 1'b0;
            after_val = bus.resp_val;
            after_rdy = bus.cmd_rdy;
        end
        obs_proto = {no_resp, !rdy_at_accept, bad_en != 0, bad_pay != 0, bad_ctl != 0,
                     unstable != 0, after_val, !after_rdy};
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (en_vec() !== 6'd0 || bus.resp_val !== 1'b0) begin
            failures++; $display("FAIL reset_hold: en=%b resp_val=%b, required en=000000 resp_val=0", en_vec(), bus.resp_val);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cmd_rdy !== 1'b1) begin
            failures++; $display("FAIL reset_cmd_rdy: got %b required 1", bus.cmd_rdy);
        end
        checks++;
        if (bus.resp_val !== 1'b0) begin
            failures++; $display("FAIL reset_resp_val: got %b required 0", bus.resp_val);
        end
        checks++;
        if ({bus.resp_err, bus.resp_op, bus.resp_data} !== 12'd0) begin
            failures++; $display("FAIL reset_resp_fields: err=%b op=%0d data=%h required all 0", bus.resp_err, bus.resp_op, bus.resp_data);
        end
        checks++;
        if (pay_vec() !== 30'd0 || en_vec() !== 6'd0) begin
            failures++; $display("FAIL reset_queue_side: pay=%h en=%b required 0", pay_vec(), en_vec());
        end
    endtask

    task automatic test_enq_back();
        res_t e;
        e = model(3'd0, 1, 8'd3);
        run_txn(3'd0, 3'd0, 8'hA5, 1, 8'd3, 0, 6'd0);
        checks++;
        if (obs_res !== e) begin failures++; $display("FAIL enq_back_result: got %h required %h", obs_res, e); end
        checks++;
        if (obs_proto !== 8'd0) begin failures++; $display("FAIL enq_back_protocol: flags %b required 00000000", obs_proto); end
        checks++;
        if (obs_res.lat !== 8'd2 || obs_res.data !== 8'h03) begin
            failures++; $display("FAIL enq_back_latency_data: lat=%0d data=%h required lat=2 data=03", obs_res.lat, obs_res.data);
        end
    endtask

    task automatic test_deq_front_hold();
        res_t e;
        e = model(3'd2, 4, 8'h5A);
        run_txn(3'd2, 3'd0, 8'h00, 4, 8'h5A, 3, 6'd0);
        checks++;
        if (obs_res !== e) begin failures++; $display("FAIL deq_front_result: got %h required %h", obs_res, e); end
        checks++;
        if (obs_proto !== 8'd0) begin failures++; $display("FAIL deq_front_protocol: flags %b required 00000000", obs_proto); end
        checks++;
        if (obs_res.en_cycles !== 8'd4 || obs_res.data !== 8'h5A) begin
            failures++; $display("FAIL deq_front_en_data: en=%0d data=%h required en=4 data=5a", obs_res.en_cycles, obs_res.data);
        end
    endtask

    task automatic test_timeout();
        res_t e;
        e = model(3'd5, 0, 8'hFF);
        run_txn(3'd5, 3'd2, 8'h77, 0, 8'hFF, 1, 6'd0);
        checks++;
        if (obs_res !== e) begin failures++; $display("FAIL timeout_result: got %h required %h", obs_res, e); end
        checks++;
        if (obs_proto !== 8'd0) begin failures++; $display("FAIL timeout_protocol: flags %b required 00000000", obs_proto); end
        checks++;
        if (obs_res.en_cycles !== 8'(TIMEOUT) || obs_res.err !== 1'b1 || obs_res.op !== 3'd5) begin
            failures++; $display("FAIL timeout_del: en=%0d err=%b op=%0d required en=16 err=1 op=5", obs_res.en_cycles, obs_res.err, obs_res.op);
        end
    endtask

    task automatic test_cpl_at_limit();
        res_t e;
        e = model(3'd4, TIMEOUT, 8'h00);
        run_txn(3'd4, 3'd6, 8'h11, TIMEOUT, 8'h00, 0, 6'd0);
        checks++;
        if (obs_res !== e || obs_proto !== 8'd0) begin
            failures++; $display("FAIL cpl_on_last_cycle: got %h flags %b required %h flags 0", obs_res, obs_proto, e);
        end
        e = model(3'd3, TIMEOUT + 1, 8'h42);
        run_txn(3'd3, 3'd0, 8'h00, TIMEOUT + 1, 8'h42, 0, 6'd0);
        checks++;
        if (obs_res !== e || obs_proto !== 8'd0) begin
            failures++; $display("FAIL cpl_after_limit: got %h flags %b required %h flags 0", obs_res, obs_proto, e);
        end
    endtask

    task automatic test_illegal();
        res_t e;
        for (int k = 6; k <= 7; k++) begin
            e = model(3'(k), 1, 8'hEE);
            run_txn(3'(k), 3'd1, 8'hEE, 1, 8'hEE, 1, 6'h3F);
            checks++;
            if (obs_res !== e || obs_proto !== 8'd0) begin
                failures++; $display("FAIL illegal_op%0d: got %h flags %b required %h flags 0", k, obs_res, obs_proto, e);
            end
        end
    endtask

    task automatic test_stray_cpl();
        res_t e;
        e = model(3'd4, 5, 8'h00);
        run_txn(3'd4, 3'd1, 8'h9C, 5, 8'h00, 0, 6'b000001);
        checks++;
        if (obs_res !== e || obs_proto !== 8'd0) begin
            failures++; $display("FAIL stray_enq_back_cpl: got %h flags %b required %h flags 0", obs_res, obs_proto, e);
        end
        e = model(3'd4, 3, 8'h00);
        run_txn(3'd4, 3'd7, 8'h3E, 3, 8'h00, 0, 6'b101111);
        checks++;
        if (obs_res !== e || obs_proto !== 8'd0) begin
            failures++; $display("FAIL stray_all_others: got %h flags %b required %h flags 0", obs_res, obs_proto, e);
        end
    endtask

    task automatic test_reset_mid_issue();
        bus.cmd_val = 1'b1; bus.cmd_op = 3'd4; bus.cmd_tag = 3'd5; bus.cmd_data = 8'h3C;
        drive_cpl(6'd0);
        @(posedge clk); @(negedge clk);
        bus.cmd_val = 1'b0;
        checks++;
        if (bus.upd_en !== 1'b1) begin failures++; $display("FAIL rst_mid_issue_started: upd_en=%b required 1", bus.upd_en); end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.upd_en !== 1'b0 || pay_vec() !== 30'd0) begin
            failures++; $display("FAIL rst_mid_issue_async: upd_en=%b pay=%h required 0", bus.upd_en, pay_vec());
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.resp_val !== 1'b0 || bus.cmd_rdy !== 1'b1 || en_vec() !== 6'd0) begin
                failures++; $display("FAIL rst_mid_issue_after%0d: resp_val=%b cmd_rdy=%b en=%b required 0 1 0", k, bus.resp_val, bus.cmd_rdy, en_vec());
            end
        end
    endtask

    task automatic test_random();
        res_t       e;
        logic [2:0] op;
        logic [7:0] ret;
        logic [5:0] stray;
        int         cpl_at;
        for (int n = 0; n < 40; n++) begin
            op     = 3'($urandom_range(0, 7));
            cpl_at = $urandom_range(0, TIMEOUT + 3);
            ret    = 8'($urandom);
            stray  = ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'd0;
            e = model(op, cpl_at, ret);
            run_txn(op, 3'($urandom), 8'($urandom), cpl_at, ret, $urandom_range(0, 3), stray);
            checks++;
            if (obs_res !== e) begin
                failures++; $display("FAIL random_result[%0d] op=%0d cpl_at=%0d: got %h required %h", n, op, cpl_at, obs_res, e);
            end
            checks++;
            if (obs_proto !== 8'd0) begin
                failures++; $display("FAIL random_protocol[%0d] op=%0d: flags %b required 00000000", n, op, obs_proto);
            end
        end
    endtask

    initial begin
        test_reset();
        test_enq_back();
        test_deq_front_hold();
        test_timeout();
        test_cpl_at_limit();
        test_illegal();
        test_stray_cpl();
        test_reset_mid_issue();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation still running at %0t", $time);
        $fatal(1, "time limit");
    end
endmodule

// File: doc/queue_op_issuer.md
QUEUE_OP_ISSUER -- requirements
Module: queue_op_issuer

Interface
- REQ-001 SHALL have parameter p_depth, default `TOP_DEPTH; queue entries.
- REQ-002 SHALL have parameter p_ptrwidth, default $clog2(p_depth); tag width.
- REQ-003 SHALL have parameter p_chanwidth, default `TOP_CHANWIDTH; payload width.
- REQ-004 SHALL have parameter p_timeout, default 16; maximum cycles an op waits for its completion.
- REQ-005 SHALL have ports as follows, with one clock and an asynchronous, active-low reset:
  - clk  input  1  sole clock, rising edge
  - rst  input  1  asynchronous active-low reset
  - cmd_val  input  1  command valid
  - cmd_rdy  output  1  command accepted
  - cmd_op  input  3  opcode: 0 enq_back, 1 enq_front, 2 deq_front, 3 deq_back, 4 upd, 5 del, 6-7 illegal
  - cmd_tag  input  p_ptrwidth  tag for upd/del
  - cmd_data  input  p_chanwidth  payload for enq/upd
  - resp_val  output  1  response valid
  - resp_rdy  input  1  response accepted
  - resp_op  output  3  opcode of the completed command
  - resp_data  output  p_chanwidth  returned tag (zero-extended) for enq; dequeued data for deq; 0 otherwise
  - resp_err  output  1  timeout or illegal opcode
  - enq_back_en, enq_front_en, deq_front_en, deq_back_en, upd_en, del_en  output  1 each  op request to queue
  - enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl, upd_cpl, del_cpl  input  1 each  op completion from queue
  - enq_back_data, enq_front_data, upd_data_in  output  p_chanwidth  payload to queue
  - upd_tag_in, del_tag_in  output  p_ptrwidth  tag to queue
  - enq_back_tag_out, enq_front_tag_out  input  p_ptrwidth  tag returned by queue
  - deq_front_data, deq_back_data  input  p_chanwidth  data returned by queue

Function
- REQ-006 SHALL implement FSM states IDLE, ISSUE, RESP.
- REQ-007 In IDLE, cmd_rdy SHALL be 1; all other states SHALL drive cmd_rdy 0.
- REQ-008 On cmd_val and cmd_rdy at a clock edge with legal opcode: SHALL latch op/tag/data, go to ISSUE, and assert exactly one matching *_en from the next cycle.
- REQ-009 On an accepted illegal opcode: SHALL go directly to RESP with resp_err=1 and resp_data=0; no *_en asserted.
- REQ-010 All *_en, payload and tag outputs SHALL be registered; payload/tag SHALL be held stable while *_en=1; inactive ops' outputs SHALL be 0.
- REQ-011 In ISSUE, *_en SHALL stay high until the matching *_cpl is sampled 1; *_cpl of non-issued ops SHALL be ignored.
- REQ-012 At the cpl edge: SHALL capture the return value (tag_out or deq data), drop *_en next cycle, and go to RESP with resp_err=0.
- REQ-013 A wait counter SHALL clear on entry to ISSUE and increment each ISSUE cycle. If p_timeout cycles elapse without cpl: SHALL drop *_en and go to RESP with resp_err=1, resp_data=0.
- REQ-014 If cpl arrives in the same cycle the counter reaches p_timeout: cpl SHALL win, with resp_err=0.
- REQ-015 In RESP, resp_val SHALL be 1 with resp_op/resp_data/resp_err stable; on resp_rdy SHALL return to IDLE.
- REQ-016 Next-command acceptance SHALL occur no earlier than the cycle after the response handshake; at most one op SHALL be outstanding.
- REQ-017 Minimum latency, cmd accept to resp_val, SHALL be 2 cycles when cpl returns in the first ISSUE cycle.
- REQ-018 SHALL drive resp_val=0 outside RESP.

Reset
- REQ-019 rst=0 SHALL asynchronously force IDLE, clear the counter and captured value, and drive all *_en, resp_val, resp_err, resp_op, resp_data, payloads and tags to 0. cmd_rdy SHALL be 1 after reset release.
- REQ-020 Reset during ISSUE SHALL drop *_en immediately; the op SHALL be abandoned with no response.

Verification
- REQ-021 cmd enq_back data=0xA5, enq_back_cpl next cycle with tag_out=3 -> enq_back_en high 1 cycle; resp_op=0, resp_data=3, resp_err=0.
- REQ-022 cmd deq_front, cpl after 4 cycles with data=0x5A, resp_rdy low 3 cycles -> en high 4 cycles; resp held 3 cycles; resp_data=0x5A.
- REQ-023 cmd del tag=2, no cpl -> del_en high 16 cycles then low; resp_err=1, resp_op=5.
- REQ-024 cmd_op=7 -> no *_en ever; resp_val next cycle with resp_err=1.
- REQ-025 upd in flight, stray enq_back_cpl=1 -> ignored; upd completes only on upd_cpl.
- REQ-026 rst=0 mid-ISSUE -> upd_en=0 same cycle; after release resp_val=0, cmd_rdy=1.
